// File: rtl/fifo_pkg.sv
// Shared types and sizes for the 8-deep, 6-bit synchronous FIFO and its read-side controller.
package fifo_pkg;

    localparam int FIFO_WIDTH = 6;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
    typedef logic [FIFO_LVL_W-1:0] fifo_level_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    function automatic logic [1:0] skid_count(input skid_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry valid/ready skid buffer: captures FIFO words and presents the oldest on m_data.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    output logic [1:0]       buf_cnt_o
);

    skid_state_e      state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;

    // head_q is always the oldest word; tail_q only matters in TWO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (capture_i) begin
                        head_q  <= data_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (capture_i && pop_i) begin
                        head_q <= data_i;
                    end else if (capture_i) begin
                        tail_q  <= data_i;
                        state_q <= TWO;
                    end else if (pop_i) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop_i) begin
                        head_q <= tail_q;
                        if (capture_i) begin
                            tail_q <= data_i;
                        end else begin
                            state_q <= ONE;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign m_data_o  = head_q;
    assign buf_cnt_o = skid_count(state_q);
    assign m_valid_o = (state_q != EMPTY);

    // The issue rule in the parent never lets a third word arrive while full.
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture_i && !pop_i && state_q == TWO));

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: shadows FIFO occupancy, issues reads, streams words through a skid buffer.
// Define FIFO_READER_COUNT_EN to add the 16-bit words_out transfer counter.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_wr_seen,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LVL_W-1:0] level,
    output logic             overflow
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [15:0]      words_out
`endif
);

    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             inflight_q;
    logic [1:0]       buf_cnt;
    logic             pop;
    logic [2:0]       occ;

    assign pop = m_valid && m_ready;

    // Words already committed downstream after this edge: buffered + in flight - leaving.
    // A pop implies buf_cnt >= 1, so this never underflows.
    assign occ        = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
    assign fifo_rd_en = (level_q != '0) && (occ < 3'd2);

    always_comb begin
        level_d    = level_q;
        overflow_d = overflow_q;
        if (fifo_wr_seen && !fifo_rd_en) begin
            if (level_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                level_d = level_q + LVL_W'(1);
            end
        end else if (fifo_rd_en && !fifo_wr_seen) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            overflow_q <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            overflow_q <= overflow_d;
            inflight_q <= fifo_rd_en;
        end
    end

    fifo_reader_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (inflight_q),
        .data_i    (fifo_data),
        .pop_i     (pop),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .buf_cnt_o (buf_cnt)
    );

    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef FIFO_READER_COUNT_EN
    logic [15:0] words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else if (pop) begin
            words_q <= words_q + 16'd1;
        end
    end

    assign words_out = words_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO and a word-order scoreboard.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_wr_seen = 1'b0;
    logic       fifo_rd_en;
    logic [5:0] fifo_data = '0;
    logic [5:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [3:0] level;
    logic       overflow;
    logic [5:0] wdata = '0;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0] words_out;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nxfer = 0;
    int nrd = 0;
    int first_x = -1;
    int last_x = -1;
    int base_x;
    int base_rd;

    logic [5:0] sb[$];
    logic [5:0] fifo_mem[$];

    always #5 clk = ~clk;

    fifo_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_wr_seen (fifo_wr_seen),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data    (fifo_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .overflow     (overflow)
`ifdef FIFO_READER_COUNT_EN
        ,
        .words_out    (words_out)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural 8-deep FIFO: registered output, writes dropped when full.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
        if (fifo_wr_seen && fifo_mem.size() < 8) fifo_mem.push_back(wdata);
    end

    // Outputs are sampled on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && fifo_rd_en) nrd++;
        if (rst_n && m_valid && m_ready) begin
            nxfer++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("m_data_order", 32'(m_data), 32'(sb.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] d, input bit expect_out);
        fifo_wr_seen = 1'b1;
        wdata = d;
        if (expect_out) sb.push_back(d);
        tick();
        fifo_wr_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_wr_seen = 1'b0;
        fifo_mem.delete();
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_READER_COUNT_EN
        chk("rst_words_out", 32'(words_out), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Single word: read after E0, capture at E2.
        m_ready = 1'b1;
        base_x = nxfer;
        wr(6'h2A, 1'b1);
        chk("single_rd_en_e0", 32'(fifo_rd_en), 32'd1);
        chk("single_level_e0", 32'(level), 32'd1);
        tick();
        chk("single_rd_en_e1", 32'(fifo_rd_en), 32'd0);
        chk("single_level_e1", 32'(level), 32'd0);
        chk("single_valid_e1", 32'(m_valid), 32'd0);
        tick();
        chk("single_valid_e2", 32'(m_valid), 32'd1);
        chk("single_data_e2", 32'(m_data), 32'h2A);
        tick();
        chk("single_valid_e3", 32'(m_valid), 32'd0);
        chk("single_count", 32'(nxfer - base_x), 32'd1);

        // Burst at full throughput.
        base_x = nxfer;
        first_x = -1;
        for (int i = 1; i <= 8; i++) wr(6'(i), 1'b1);
        repeat (6) tick();
        chk("burst_count", 32'(nxfer - base_x), 32'd8);
        chk("burst_span", 32'(last_x - first_x), 32'd7);
        chk("burst_sb_empty", 32'(sb.size()), 32'd0);
        chk("burst_overflow", 32'(overflow), 32'd0);
        chk("burst_level", 32'(level), 32'd0);

        // Back-pressure: only two reads while blocked.
        m_ready = 1'b0;
        base_x = nxfer;
        base_rd = nrd;
        for (int i = 0; i < 8; i++) wr(6'(8'h11 + i), 1'b1);
        repeat (3) tick();
        chk("bp_reads", 32'(nrd - base_rd), 32'd2);
        chk("bp_level", 32'(level), 32'd6);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_head", 32'(m_data), 32'h11);
        chk("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
        tick();
        chk("bp_head_stable", 32'(m_data), 32'h11);
        first_x = -1;
        m_ready = 1'b1;
        #1;
        chk("bp_rd_en_same_cycle", 32'(fifo_rd_en), 32'd1);
        repeat (12) tick();
        chk("bp_count", 32'(nxfer - base_x), 32'd8);
        chk("bp_span", 32'(last_x - first_x), 32'd7);
        chk("bp_level_drained", 32'(level), 32'd0);

        // Overflow: 10 writes fill level to 8, the 11th is lost and sets the sticky flag.
        do_reset();
        m_ready = 1'b0;
        base_x = nxfer;
        for (int i = 0; i < 10; i++) wr(6'(8'h20 + i), 1'b1);
        chk("ovf_level_full", 32'(level), 32'd8);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        wr(6'h3F, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level_sat", 32'(level), 32'd8);
        m_ready = 1'b1;
        repeat (20) tick();
        chk("ovf_drain_count", 32'(nxfer - base_x), 32'd10);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_level_drained", 32'(level), 32'd0);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Asynchronous reset with a full skid buffer and words still resident.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(6'(8'h30 + i), 1'b1);
        tick();
        chk("mid_valid_before", 32'(m_valid), 32'd1);
        chk("mid_level_before", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(m_valid), 32'd0);
        chk("mid_data", 32'(m_data), 32'd0);
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        fifo_mem.delete();
        sb.delete();
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        base_x = nxfer;
        repeat (5) tick();
        chk("mid_no_stale", 32'(nxfer - base_x), 32'd0);
        wr(6'h3C, 1'b1);
        repeat (4) tick();
        chk("mid_after_count", 32'(nxfer - base_x), 32'd1);
        chk("mid_after_sb", 32'(sb.size()), 32'd0);

`ifdef FIFO_READER_COUNT_EN
        do_reset();
        chk("cnt_reset", 32'(words_out), 32'd0);
        m_ready = 1'b1;
        base_x = nxfer;
        for (int i = 0; i < 70000; i++) wr(6'(i), 1'b1);
        repeat (6) tick();
        chk("cnt_transfers", 32'(nxfer - base_x), 32'd70000);
        chk("cnt_wrap", 32'(words_out), 32'd4464);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
